// File: rtl/exec_datapath_md.sv
// rtl/exec_datapath_md.sv - execute-stage datapath: regfile, imm gen, ALU, branch compare, iterative mul/div
module exec_datapath_md #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     ins,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] data_in,
  input  logic            regwen,
  input  logic [2:0]      immsel,
  input  logic            asel,
  input  logic            bsel,
  input  logic            brun,
  input  logic [3:0]      alusel,
  input  logic            md_start,
  input  logic [1:0]      md_op,
  output logic [XLEN-1:0] alu_res,
  output logic [XLEN-1:0] data_B,
  output logic            breq,
  output logic            brlt,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_res
);
  localparam int SHW  = $clog2(XLEN);
  localparam int CNTW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_e;

  logic [4:0] rd, rs1, rs2;
  logic       ins_unused;
  assign rd         = ins[11:7];
  assign rs1        = ins[19:15];
  assign rs2        = ins[24:20];
  // opcode bits are decoded upstream; only the operand fields matter here
  assign ins_unused = ^ins[6:0];

  // ---------------------------------------------------------------- regfile
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            rf_wen;
  logic [XLEN-1:0] rs1_rf, rs2_rf, rs1_val, rs2_val;

  // x0 and out-of-range destinations never take a write
  assign rf_wen = regwen && (rd != 5'd0) && (int'(rd) < NREG);

  // Next regfile contents: at most one entry takes the write-back data
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (rf_wen && (int'(rd) == i)) regs_d[i] = data_in;
    end
  end

  // Register storage, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Async read ports; x0 and unimplemented indices read zero, optional write forwarding
  always_comb begin
    rs1_rf = '0;
    rs2_rf = '0;
    for (int i = 1; i < NREG; i++) begin
      if (int'(rs1) == i) rs1_rf = regs_q[i];
      if (int'(rs2) == i) rs2_rf = regs_q[i];
    end
    rs1_val = rs1_rf;
    rs2_val = rs2_rf;
    if (BYPASS && rf_wen && (rd == rs1)) rs1_val = data_in;
    if (BYPASS && rf_wen && (rd == rs2)) rs2_val = data_in;
  end

  // ------------------------------------------------------------- immediate
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;

  // RISC-V immediate formats, built at 32 bits then widened/narrowed to XLEN
  always_comb begin
    case (immsel)
      3'd1:    imm32 = {{20{ins[31]}}, ins[31:20]};
      3'd2:    imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'd3:    imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd4:    imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd5:    imm32 = {ins[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_imm_wide
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_imm_narrow
      assign imm = imm32[XLEN-1:0];
    end
  endgenerate

  // -------------------------------------------------------------------- ALU
  logic [XLEN-1:0] op1, op2;
  logic [SHW-1:0]  shamt;

  // Operand select and combinational ALU
  always_comb begin
    op1   = asel ? pc : rs1_val;
    op2   = bsel ? imm : rs2_val;
    shamt = op2[SHW-1:0];
    case (alusel)
      4'd0:    alu_res = op1 + op2;
      4'd1:    alu_res = op1 - op2;
      4'd2:    alu_res = op1 & op2;
      4'd3:    alu_res = op1 | op2;
      4'd4:    alu_res = op1 ^ op2;
      4'd5:    alu_res = op1 << shamt;
      4'd6:    alu_res = op1 >> shamt;
      4'd7:    alu_res = XLEN'($signed(op1) >>> shamt);
      4'd8:    alu_res = XLEN'($signed(op1) < $signed(op2));
      4'd9:    alu_res = XLEN'(op1 < op2);
      4'd10:   alu_res = op2;
      default: alu_res = '0;
    endcase
  end

  // Branch comparator and store data always see register operands
  always_comb begin
    data_B = rs2_val;
    breq   = (rs1_val == rs2_val);
    brlt   = brun ? (rs1_val < rs2_val) : ($signed(rs1_val) < $signed(rs2_val));
  end

  // ------------------------------------------------------------ mul / div
  md_state_e       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier->product low half / dividend->quotient
  logic [XLEN-1:0] opb_q, opb_d;     // multiplicand / divisor
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] md_res_q, md_res_d;
  logic            md_accept, run_last, div_fit;
  logic [XLEN:0]   mul_sum, rem_sh;

  assign md_accept = md_start && (state_q != S_RUN);
  assign run_last  = (cnt_q == CNTW'(XLEN));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: one extra RUN cycle after the last iteration publishes the result
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (md_start) state_d = S_RUN;
      S_RUN:   if (run_last) state_d = S_DONE;
      S_DONE:  state_d = md_start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    md_busy = (state_q == S_RUN);
    md_done = (state_q == S_DONE);
  end

  // Iteration step: shift-add multiply or restoring divide, one bit per cycle
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    op_d     = op_q;
    md_res_d = md_res_q;
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {acc_q, lo_q[XLEN-1]};
    div_fit  = (rem_sh >= {1'b0, opb_q});
    if (md_accept) begin
      cnt_d = '0;
      acc_d = '0;
      lo_d  = rs1_val;
      opb_d = rs2_val;
      op_d  = md_op;
    end else if (state_q == S_RUN) begin
      if (run_last) begin
        case (op_q)
          2'd0:    md_res_d = lo_q;
          2'd1:    md_res_d = acc_q;
          2'd2:    md_res_d = lo_q;
          default: md_res_d = acc_q;
        endcase
      end else begin
        cnt_d = cnt_q + CNTW'(1);
        if (op_q[1]) begin
          // divide by zero naturally yields all-ones quotient and remainder = dividend
          acc_d = div_fit ? XLEN'(rem_sh - {1'b0, opb_q}) : rem_sh[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], div_fit};
        end else begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
      end
    end
  end

  // Mul/div datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      md_res_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      md_res_q <= md_res_d;
    end
  end

  assign md_res = md_res_q;

endmodule
